// File: rtl/freq_count.sv
// Counts occurrences of symbols 0-9 into ten saturating 13-bit weights; raises count_over for one cycle when the frame ends.
// Latency: one cycle from an accepted symbol to FREQUENT_OUT; count_over is high the cycle after the last symbol. There is no backpressure: one symbol per cycle.
module freq_count (
    input  logic         CLK,
    input  logic         nRST,
    input  logic         count_begin,
    input  logic [3:0]   SYMBOL_IN,
    input  logic         symbol_valid,
    input  logic         symbol_last,
    output logic         busy,
    output logic         count_over,
    output logic         bad_symbol,
    output logic [129:0] FREQUENT_OUT
);

    localparam logic [1:0]  ST_IDLE  = 2'd0;
    localparam logic [1:0]  ST_COUNT = 2'd1;
    localparam logic [1:0]  ST_DONE  = 2'd2;
    localparam logic [12:0] W_MAX    = 13'h1FFF;
    localparam int          N_SYM    = 10;

    logic [1:0]  state_q, state_d;
    logic [12:0] cnt_q [N_SYM];
    logic [12:0] cnt_d [N_SYM];
    logic        bad_q, bad_d;
    logic        busy_q, busy_d;
    logic        over_q, over_d;

    always_comb begin
        state_d = state_q;
        bad_d   = bad_q;
        for (int k = 0; k < N_SYM; k++) begin
            cnt_d[k] = cnt_q[k];
        end

        case (state_q)
            ST_IDLE: begin
                if (count_begin) begin
                    state_d = ST_COUNT;
                    bad_d   = 1'b0;
                    for (int k = 0; k < N_SYM; k++) begin
                        cnt_d[k] = '0;
                    end
                end
            end
            ST_COUNT: begin
                if (symbol_valid) begin
                    // Symbols 10-15 are still consumed: they only flag bad_symbol.
                    if (SYMBOL_IN > 4'd9) begin
                        bad_d = 1'b1;
                    end
                    for (int k = 0; k < N_SYM; k++) begin
                        if (SYMBOL_IN == k[3:0] && cnt_q[k] != W_MAX) begin
                            cnt_d[k] = cnt_q[k] + 13'd1;
                        end
                    end
                    if (symbol_last) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
        over_d = (state_d == ST_DONE);
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= ST_IDLE;
            bad_q   <= 1'b0;
            busy_q  <= 1'b0;
            over_q  <= 1'b0;
            for (int k = 0; k < N_SYM; k++) begin
                cnt_q[k] <= '0;
            end
        end else begin
            state_q <= state_d;
            bad_q   <= bad_d;
            busy_q  <= busy_d;
            over_q  <= over_d;
            for (int k = 0; k < N_SYM; k++) begin
                cnt_q[k] <= cnt_d[k];
            end
        end
    end

    assign busy       = busy_q;
    assign count_over = over_q;
    assign bad_symbol = bad_q;

    for (genvar g = 0; g < N_SYM; g++) begin : g_pack
        assign FREQUENT_OUT[13*g +: 13] = cnt_q[g];
    end

endmodule

// File: tb/tb_freq_count.sv
// Directed bench for freq_count: frames queue their expected weights and bad flag.
// A monitor pops that queue and compares on every count_over pulse.
module tb_freq_count;

    logic         CLK = 1'b0;
    logic         nRST;
    logic         count_begin;
    logic [3:0]   SYMBOL_IN;
    logic         symbol_valid;
    logic         symbol_last;
    logic         busy;
    logic         count_over;
    logic         bad_symbol;
    logic [129:0] FREQUENT_OUT;

    int           n_checks = 0;
    int           n_fail   = 0;
    logic [130:0] exp_q [$];
    logic [130:0] mon_e;
    logic [129:0] ev;

    freq_count dut (
        .CLK          (CLK),
        .nRST         (nRST),
        .count_begin  (count_begin),
        .SYMBOL_IN    (SYMBOL_IN),
        .symbol_valid (symbol_valid),
        .symbol_last  (symbol_last),
        .busy         (busy),
        .count_over   (count_over),
        .bad_symbol   (bad_symbol),
        .FREQUENT_OUT (FREQUENT_OUT)
    );

    always #5 CLK = ~CLK;

    function automatic logic [129:0] wv(input int k, input int val);
        logic [129:0] v;
        v = '0;
        v[13*k +: 13] = val[12:0];
        return v;
    endfunction

    task automatic chk(input string name, input logic [129:0] got, input logic [129:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Inputs change on the falling edge; the DUT samples them on the next rising edge.
    task automatic tick(input logic b, input logic v, input logic [3:0] s, input logic l);
        @(negedge CLK);
        count_begin  = b;
        symbol_valid = v;
        SYMBOL_IN    = s;
        symbol_last  = l;
    endtask

    always @(negedge CLK) begin
        if (nRST === 1'b1 && count_over === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_count_over: got 1 expected 0 at %0t", $time);
            end else begin
                mon_e = exp_q.pop_front();
                chk("frame_freq", FREQUENT_OUT, mon_e[129:0]);
                chk("frame_bad", {129'b0, bad_symbol}, {129'b0, mon_e[130]});
                chk("done_busy", {129'b0, busy}, 130'd1);
            end
        end
    end

    initial begin
        nRST = 1'b0;
        count_begin = 1'b0; symbol_valid = 1'b0; SYMBOL_IN = 4'd0; symbol_last = 1'b0;
        repeat (2) @(negedge CLK);
        chk("rst_freq", FREQUENT_OUT, '0);
        chk("rst_busy", {129'b0, busy}, '0);
        chk("rst_over", {129'b0, count_over}, '0);
        chk("rst_bad", {129'b0, bad_symbol}, '0);
        nRST = 1'b1;

        // Reset mid-frame aborts it: no count_over, counters cleared immediately.
        tick(1, 0, 0, 0);
        for (int i = 0; i < 5; i++) tick(0, 1, 4'd1, 0);
        tick(0, 0, 0, 0);
        chk("pre_abort_freq", FREQUENT_OUT, wv(1, 5));
        #2 nRST = 1'b0;
        #1;
        chk("abort_freq", FREQUENT_OUT, '0);
        chk("abort_busy", {129'b0, busy}, '0);
        @(negedge CLK);
        nRST = 1'b1;
        for (int i = 0; i < 3; i++) tick(0, 1, 4'd2, i == 2);
        tick(0, 0, 0, 0);
        chk("idle_freq", FREQUENT_OUT, '0);
        chk("idle_busy", {129'b0, busy}, '0);

        // Basic frame 3,3,7,0,9(last)
        exp_q.push_back({1'b0, wv(0, 1) | wv(3, 2) | wv(7, 1) | wv(9, 1)});
        tick(1, 0, 0, 0);
        tick(0, 1, 4'd3, 0);
        chk("begin_busy", {129'b0, busy}, 130'd1);
        chk("begin_freq", FREQUENT_OUT, '0);
        tick(0, 1, 4'd3, 0);
        chk("first_sym_freq", FREQUENT_OUT, wv(3, 1));
        tick(0, 1, 4'd7, 0);
        tick(0, 1, 4'd0, 0);
        tick(0, 1, 4'd9, 1);
        tick(0, 0, 0, 0);
        tick(0, 0, 0, 0);
        chk("post_done_busy", {129'b0, busy}, '0);
        chk("post_done_over", {129'b0, count_over}, '0);

        // Saturation: 8195 copies of symbol 5
        exp_q.push_back({1'b0, wv(5, 8191)});
        tick(1, 0, 0, 0);
        for (int i = 0; i < 8195; i++) tick(0, 1, 4'd5, i == 8194);
        tick(0, 0, 0, 0);
        tick(0, 0, 0, 0);

        // Illegal symbols 1,12,15(last)
        exp_q.push_back({1'b1, wv(1, 1)});
        tick(1, 0, 0, 0);
        tick(0, 1, 4'd1, 0);
        tick(0, 1, 4'd12, 0);
        tick(0, 1, 4'd15, 1);
        chk("bad_sticky", {129'b0, bad_symbol}, 130'd1);
        tick(0, 0, 0, 0);
        tick(0, 0, 0, 0);

        // Ignored inputs: valid on the begin cycle, last without valid, begin mid-frame
        exp_q.push_back({1'b0, wv(4, 2)});
        tick(1, 1, 4'd2, 0);
        tick(0, 0, 4'd6, 1);
        chk("clear_freq", FREQUENT_OUT, '0);
        chk("clear_bad", {129'b0, bad_symbol}, '0);
        tick(0, 1, 4'd4, 0);
        chk("last_no_valid_busy", {129'b0, busy}, 130'd1);
        tick(1, 0, 0, 0);
        tick(0, 1, 4'd4, 1);
        chk("midframe_begin_freq", FREQUENT_OUT, wv(4, 1));
        chk("midframe_begin_busy", {129'b0, busy}, 130'd1);

        // Back-to-back frame: begin during the first IDLE cycle, then 8(last)
        exp_q.push_back({1'b0, wv(8, 1)});
        tick(0, 0, 0, 0);
        tick(1, 0, 0, 0);
        chk("b2b_idle_busy", {129'b0, busy}, '0);
        ev = wv(4, 2);
        chk("b2b_hold_freq", FREQUENT_OUT, ev);
        tick(0, 1, 4'd8, 1);
        chk("b2b_clear_freq", FREQUENT_OUT, '0);
        chk("b2b_busy", {129'b0, busy}, 130'd1);
        tick(0, 0, 0, 0);
        tick(0, 0, 0, 0);
        chk("b2b_end_busy", {129'b0, busy}, '0);
        repeat (3) tick(0, 0, 0, 0);

        chk("sb_drained", 130'(exp_q.size()), '0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
